// File: rtl/id_stage_pipe_if.sv
// IF/ID/EX-facing signal bundle of the decode stage. The stage takes the slave
// modport and its environment takes the master modport.
interface id_stage_pipe_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  iValid;
  logic [31:0]           iInstr;
  logic [XLEN-1:0]       iPC;
  logic                  oReady;
  logic [REG_ADDR_W-1:0] oAddrRs1;
  logic [REG_ADDR_W-1:0] oAddrRs2;
  logic [XLEN-1:0]       iRs1Data;
  logic [XLEN-1:0]       iRs2Data;
  logic                  iWbEn;
  logic [REG_ADDR_W-1:0] iWbRd;
  logic [XLEN-1:0]       iWbData;
  logic                  iExMemRead;
  logic [REG_ADDR_W-1:0] iExRd;
  logic                  iStall;
  logic                  iFlush;
  logic                  oValid;
  logic [XLEN-1:0]       oPC;
  logic [6:0]            oOpcode;
  logic [2:0]            oFunc3;
  logic [6:0]            oFunc7;
  logic [REG_ADDR_W-1:0] oRd;
  logic [REG_ADDR_W-1:0] oRs1Addr;
  logic [REG_ADDR_W-1:0] oRs2Addr;
  logic [XLEN-1:0]       oRs1Data;
  logic [XLEN-1:0]       oRs2Data;
  logic [XLEN-1:0]       oImm;
  logic                  oMemRead;
  logic                  oIllegal;
  logic [CNT_W-1:0]      oBubbleCnt;

  modport slave (
    input  iValid, iInstr, iPC, iRs1Data, iRs2Data, iWbEn, iWbRd, iWbData,
           iExMemRead, iExRd, iStall, iFlush,
    output oReady, oAddrRs1, oAddrRs2, oValid, oPC, oOpcode, oFunc3, oFunc7,
           oRd, oRs1Addr, oRs2Addr, oRs1Data, oRs2Data, oImm, oMemRead,
           oIllegal, oBubbleCnt
  );

  modport master (
    output iValid, iInstr, iPC, iRs1Data, iRs2Data, iWbEn, iWbRd, iWbData,
           iExMemRead, iExRd, iStall, iFlush,
    input  oReady, oAddrRs1, oAddrRs2, oValid, oPC, oOpcode, oFunc3, oFunc7,
           oRd, oRs1Addr, oRs2Addr, oRs1Data, oRs2Data, oImm, oMemRead,
           oIllegal, oBubbleCnt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage: decode, operand read, load-use bubbles, ID/EX slot.
// Define ID_WB_BYPASS_EN to forward the write-back port into the operand read.
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic            iClk,
  input  logic            iRst,
  id_stage_pipe_if.slave  bus
);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_MISC   = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic                  mem_read;
    logic                  illegal;
  } idex_t;

  // An empty slot reads as addi x0,x0,0 so EX can treat it as a NOP.
  function automatic idex_t bubble();
    idex_t b = '0;
    b.opcode = OPC_OPIMM;
    return b;
  endfunction

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
  logic                  known_op, uses_rs1, uses_rs2, load_use;
  logic signed [31:0]    imm32;
  logic [XLEN-1:0]       rs1_val, rs2_val;
  idex_t                 slot_q, slot_d, decoded;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready;

  assign instr        = bus.iInstr;
  assign opcode       = instr[6:0];
  assign rs1_addr     = REG_ADDR_W'(instr[19:15]);
  assign rs2_addr     = REG_ADDR_W'(instr[24:20]);
  assign bus.oAddrRs1 = rs1_addr;
  assign bus.oAddrRs2 = rs2_addr;

  assign known_op = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                   OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISC,
                                   OPC_SYSTEM};
  assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  assign load_use = bus.iValid && bus.iExMemRead && (bus.iExRd != '0) &&
                    ((uses_rs1 && rs1_addr == bus.iExRd) ||
                     (uses_rs2 && rs2_addr == bus.iExRd));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    imm32 = '0;
    unique case (opcode)
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

`ifdef ID_WB_BYPASS_EN
  always_comb begin
    rs1_val = (rs1_addr == '0) ? '0 : bus.iRs1Data;
    rs2_val = (rs2_addr == '0) ? '0 : bus.iRs2Data;
    if (rs1_addr != '0 && bus.iWbEn && bus.iWbRd == rs1_addr) rs1_val = bus.iWbData;
    if (rs2_addr != '0 && bus.iWbEn && bus.iWbRd == rs2_addr) rs2_val = bus.iWbData;
  end
`else
  // The regfile writes in the first half-cycle, so its read data is already current.
  assign rs1_val = (rs1_addr == '0) ? '0 : bus.iRs1Data;
  assign rs2_val = (rs2_addr == '0) ? '0 : bus.iRs2Data;
  logic unused_wb;
  assign unused_wb = ^{bus.iWbEn, bus.iWbRd, bus.iWbData};
`endif

  always_comb begin
    decoded          = bubble();
    decoded.valid    = 1'b1;
    decoded.pc       = bus.iPC;
    decoded.opcode   = opcode;
    decoded.func3    = instr[14:12];
    decoded.func7    = instr[31:25];
    decoded.rd       = REG_ADDR_W'(instr[11:7]);
    decoded.rs1      = rs1_addr;
    decoded.rs2      = rs2_addr;
    decoded.rs1_data = rs1_val;
    decoded.rs2_data = rs2_val;
    decoded.imm      = XLEN'(imm32);
    decoded.mem_read = (opcode == OPC_LOAD);
    decoded.illegal  = (instr[1:0] != 2'b11) || !known_op;
  end

  // Flush outranks stall, which outranks a load-use bubble.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    ready  = 1'b0;
    if (bus.iFlush) begin
      slot_d = bubble();
      ready  = 1'b1;
    end else if (bus.iStall) begin
      slot_d = slot_q;
    end else if (load_use) begin
      slot_d = bubble();
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      slot_d = bus.iValid ? decoded : bubble();
      ready  = 1'b1;
    end
  end

  assign bus.oReady = ready && !iRst;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      slot_q <= bubble();
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.oValid     = slot_q.valid;
  assign bus.oPC        = slot_q.pc;
  assign bus.oOpcode    = slot_q.opcode;
  assign bus.oFunc3     = slot_q.func3;
  assign bus.oFunc7     = slot_q.func7;
  assign bus.oRd        = slot_q.rd;
  assign bus.oRs1Addr   = slot_q.rs1;
  assign bus.oRs2Addr   = slot_q.rs2;
  assign bus.oRs1Data   = slot_q.rs1_data;
  assign bus.oRs2Data   = slot_q.rs2_data;
  assign bus.oImm       = slot_q.imm;
  assign bus.oMemRead   = slot_q.mem_read;
  assign bus.oIllegal   = slot_q.illegal;
  assign bus.oBubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus hazard, bypass,
// stall/flush, counter saturation and reset sequences.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int CW   = 3;

`ifdef ID_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_EXP = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  id_stage_pipe_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) bus ();

  id_stage_pipe #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc, rs1d, rs2d;
    logic        e_valid;
    logic [6:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_pc, e_imm, e_r1, e_r2;
    logic        e_mem, e_ill;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.iValid   = v;
    bus.iInstr   = instr;
    bus.iPC      = pc;
    bus.iRs1Data = r1;
    bus.iRs2Data = r2;
  endtask

  task automatic check_nop(input string tag, input logic [CW-1:0] cnt);
    check({tag, ".valid"}, bus.oValid, 1'b0);
    check({tag, ".op"},    bus.oOpcode, 7'h13);
    check({tag, ".pc"},    bus.oPC, 32'h0);
    check({tag, ".rd"},    bus.oRd, 5'd0);
    check({tag, ".imm"},   bus.oImm, 32'h0);
    check({tag, ".r1"},    bus.oRs1Data, 32'h0);
    check({tag, ".mem"},   bus.oMemRead, 1'b0);
    check({tag, ".ill"},   bus.oIllegal, 1'b0);
    check({tag, ".cnt"},   bus.oBubbleCnt, cnt);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h00500093, 32'h100, 32'hAAAAAAAA, 32'h55,
                 1'b1, 7'h13, 5'd1,  32'h100, 32'h5,        32'h0,    32'h55, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hFE208EE3, 32'h104, 32'h11,       32'h22,
                 1'b1, 7'h63, 5'd29, 32'h104, 32'hFFFFFFFC, 32'h11,   32'h22, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0080A283, 32'h108, 32'h1000,     32'h44,
                 1'b1, 7'h03, 5'd5,  32'h108, 32'h8,        32'h1000, 32'h44, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'hFE20AE23, 32'h10C, 32'h2000,     32'h33,
                 1'b1, 7'h23, 5'd28, 32'h10C, 32'hFFFFFFFC, 32'h2000, 32'h33, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h123452B7, 32'h110, 32'h77,       32'h66,
                 1'b1, 7'h37, 5'd5,  32'h110, 32'h12345000, 32'h77,   32'h66, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h008000EF, 32'h114, 32'h99,       32'h88,
                 1'b1, 7'h6F, 5'd1,  32'h114, 32'h8,        32'h0,    32'h88, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'hFFFFF217, 32'h118, 32'h12,       32'h34,
                 1'b1, 7'h17, 5'd4,  32'h118, 32'hFFFFF000, 32'h12,   32'h34, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'h11C, 32'h5,        32'h6,
                 1'b1, 7'h7F, 5'd31, 32'h11C, 32'h0,        32'h5,    32'h6,  1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h00500093, 32'h120, 32'h1,        32'h2,
                 1'b0, 7'h13, 5'd0,  32'h0,   32'h0,        32'h0,    32'h0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h00000010, 32'h124, 32'h7,        32'h8,
                 1'b1, 7'h10, 5'd0,  32'h124, 32'h0,        32'h0,    32'h0,  1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'h00000073, 32'h128, 32'h7,        32'h8,
                 1'b1, 7'h73, 5'd0,  32'h128, 32'h0,        32'h0,    32'h0,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'hFF808067, 32'h12C, 32'h3,        32'h4,
                 1'b1, 7'h67, 5'd0,  32'h12C, 32'hFFFFFFF8, 32'h3,    32'h4,  1'b0, 1'b0};

    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.iWbEn = 1'b0; bus.iWbRd = '0; bus.iWbData = '0;
    bus.iExMemRead = 1'b0; bus.iExRd = '0;
    bus.iStall = 1'b0; bus.iFlush = 1'b0;

    // Reset state
    step(); step();
    check_nop("reset", 3'd0);
    check("reset.ready", bus.oReady, 1'b0);
    rst = 1'b0;

    // Decode table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d);
      #1;
      check($sformatf("v%0d.ready", i), bus.oReady, 1'b1);
      check($sformatf("v%0d.addr1", i), bus.oAddrRs1, vecs[i].instr[19:15]);
      step();
      check($sformatf("v%0d.valid", i), bus.oValid, vecs[i].e_valid);
      check($sformatf("v%0d.op", i), bus.oOpcode, vecs[i].e_op);
      check($sformatf("v%0d.rd", i), bus.oRd, vecs[i].e_rd);
      check($sformatf("v%0d.pc", i), bus.oPC, vecs[i].e_pc);
      check($sformatf("v%0d.imm", i), bus.oImm, vecs[i].e_imm);
      check($sformatf("v%0d.r1", i), bus.oRs1Data, vecs[i].e_r1);
      check($sformatf("v%0d.r2", i), bus.oRs2Data, vecs[i].e_r2);
      check($sformatf("v%0d.mem", i), bus.oMemRead, vecs[i].e_mem);
      check($sformatf("v%0d.ill", i), bus.oIllegal, vecs[i].e_ill);
      check($sformatf("v%0d.cnt", i), bus.oBubbleCnt, 3'd0);
    end

    // Load-use on rs2: add x3,x1,x2 behind a load to x2
    drive(1'b1, 32'h002081B3, 32'h200, 32'h1, 32'h2);
    bus.iExMemRead = 1'b1; bus.iExRd = 5'd2;
    #1 check("lu2.ready", bus.oReady, 1'b0);
    step();
    check("lu2.valid", bus.oValid, 1'b0);
    check("lu2.cnt", bus.oBubbleCnt, 3'd1);
    bus.iExMemRead = 1'b0;
    #1 check("lu2.ready_after", bus.oReady, 1'b1);
    step();
    check("lu2.issue_valid", bus.oValid, 1'b1);
    check("lu2.issue_op", bus.oOpcode, 7'h33);
    check("lu2.issue_rd", bus.oRd, 5'd3);
    check("lu2.issue_pc", bus.oPC, 32'h200);
    check("lu2.issue_cnt", bus.oBubbleCnt, 3'd1);

    // Load-use on rs1
    bus.iExMemRead = 1'b1; bus.iExRd = 5'd1;
    step();
    check("lu1.valid", bus.oValid, 1'b0);
    check("lu1.cnt", bus.oBubbleCnt, 3'd2);

    // Load into x0 never stalls
    bus.iExRd = 5'd0;
    #1 check("lux0.ready", bus.oReady, 1'b1);
    step();
    check("lux0.valid", bus.oValid, 1'b1);
    check("lux0.cnt", bus.oBubbleCnt, 3'd2);

    // LUI does not read its rs1 field (x8)
    drive(1'b1, 32'h123452B7, 32'h204, 32'h0, 32'h0);
    bus.iExRd = 5'd8;
    step();
    check("lui.valid", bus.oValid, 1'b1);
    check("lui.cnt", bus.oBubbleCnt, 3'd2);
    bus.iExMemRead = 1'b0;

    // Write-back bypass into addi x2,x1,0
    drive(1'b1, 32'h00008113, 32'h208, 32'h0, 32'h0);
    bus.iWbEn = 1'b1; bus.iWbRd = 5'd1; bus.iWbData = 32'hDEADBEEF;
    step();
    check("byp.r1", bus.oRs1Data, BYP_EXP);
    bus.iWbRd = 5'd0;
    step();
    check("byp_x0.r1", bus.oRs1Data, 32'h0);
    bus.iWbEn = 1'b0;

    // Stall holds the slot, even with a pending load-use
    drive(1'b1, 32'h00500093, 32'h300, 32'h0, 32'h0);
    step();
    check("stl.pre_pc", bus.oPC, 32'h300);
    drive(1'b1, 32'hFFFFFFFF, 32'h304, 32'h1, 32'h1);
    bus.iStall = 1'b1; bus.iExMemRead = 1'b1; bus.iExRd = 5'd31;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("stl%0d.ready", c), bus.oReady, 1'b0);
      step();
      check($sformatf("stl%0d.valid", c), bus.oValid, 1'b1);
      check($sformatf("stl%0d.pc", c), bus.oPC, 32'h300);
      check($sformatf("stl%0d.imm", c), bus.oImm, 32'h5);
      check($sformatf("stl%0d.rd", c), bus.oRd, 5'd1);
      check($sformatf("stl%0d.ill", c), bus.oIllegal, 1'b0);
      check($sformatf("stl%0d.cnt", c), bus.oBubbleCnt, 3'd2);
    end
    bus.iFlush = 1'b1;
    #1 check("flush.ready", bus.oReady, 1'b1);
    step();
    check_nop("flush", 3'd2);
    bus.iFlush = 1'b0; bus.iStall = 1'b0;

    // Bubble counter saturates
    drive(1'b1, 32'h002081B3, 32'h400, 32'h0, 32'h0);
    bus.iExRd = 5'd2;
    for (int c = 0; c < 5; c++) step();
    check("sat.cnt_full", bus.oBubbleCnt, 3'd7);
    step(); step();
    check("sat.cnt_hold", bus.oBubbleCnt, 3'd7);

    // Reset during a load-use stall
    #1 check("rstlu.ready", bus.oReady, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.iValid = 1'b0; bus.iExMemRead = 1'b0;
    check_nop("rstlu", 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised instruction-decode stage.
- Sits between IF and EX.
- Decodes the instruction fields and selects the immediate by opcode.
- Reads the register file, applies write-back bypass, detects load-use hazards and inserts bubbles.
- Produces one registered ID/EX pipeline slot with valid, stall and flush control.

Parameters:
- XLEN, 32, data and PC width in bits.
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iValid  in  1  IF slot holds a valid instruction
- iInstr  in  32  instruction word from IF
- iPC  in  XLEN  PC of iInstr
- oReady  out  1  ID accepts the IF slot this cycle
- oAddrRs1, oAddrRs2  out  REG_ADDR_W  combinational regfile read addresses, taken from iInstr[19:15] and iInstr[24:20]
- iRs1Data, iRs2Data  in  XLEN  regfile read data, same cycle
- iWbEn  in  1  write-back write enable
- iWbRd  in  REG_ADDR_W  write-back destination
- iWbData  in  XLEN  write-back data
- iExMemRead  in  1  instruction in EX is a LOAD
- iExRd  in  REG_ADDR_W  destination of the instruction in EX
- iStall  in  1  downstream stall; hold the ID/EX register
- iFlush  in  1  kill the IF slot and bubble ID/EX
- oValid  out  1  ID/EX slot valid
- oPC  out  XLEN  registered PC
- oOpcode  out  7  registered opcode
- oFunc3  out  3  registered func3
- oFunc7  out  7  registered func7
- oRd, oRs1Addr, oRs2Addr  out  REG_ADDR_W  registered register addresses
- oRs1Data, oRs2Data  out  XLEN  registered operand values
- oImm  out  XLEN  registered sign-extended immediate
- oMemRead  out  1  registered "is LOAD" flag
- oIllegal  out  1  registered illegal-instruction flag
- oBubbleCnt  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- All sequential logic on the rising edge of iClk; one clock domain.
- Reset (iRst=1):
  - oValid=0, oIllegal=0, oMemRead=0.
  - oOpcode=7'h13, all other register fields 0 (the slot reads as a NOP).
  - oBubbleCnt=0.
  - Reset wins over every other input, including mid-stall and mid-flush.
- Latency: 1 cycle from IF-slot acceptance to the ID/EX register.
- Per-cycle priority, highest first:
  - reset
  - flush: ID/EX <= bubble (oValid=0, other fields as in reset); oReady=1, so the IF slot is consumed and discarded.
  - iStall: ID/EX holds all fields; oReady=0.
  - load-use: ID/EX <= bubble; oReady=0 (IF holds its slot); oBubbleCnt increments, saturating at all-ones.
  - normal: ID/EX <= decoded slot, oValid=iValid; oReady=1.
- Load-use condition: iValid & iExMemRead & iExRd!=0 & ((usesRs1 & rs1==iExRd) | (usesRs2 & rs2==iExRd)).
  - usesRs1 is true for every opcode except LUI, AUIPC and JAL.
  - usesRs2 is true only for OP, STORE and BRANCH.
- Immediate selection, sign-extended to XLEN:
  - I-type: OP-IMM, LOAD, JALR, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH; bit 0 = 0.
  - U-type: LUI, AUIPC; low 12 bits = 0.
  - J-type: JAL; bit 0 = 0.
  - Any other opcode: immediate = 0.
- Operand resolution, per rs:
  - address 0 -> 0;
  - else if bypass active and iWbEn and iWbRd==rs -> iWbData;
  - else -> regfile data.
- oIllegal=1 when iValid and either:
  - instr[1:0]!=2'b11, or
  - the opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
  - The illegal slot still propagates with oValid=1.
- iValid=0 under normal flow: ID/EX <= bubble; oBubbleCnt does not count it.
- iStall held across several cycles: outputs stay bit-identical; a load-use condition during a stall neither bubbles nor counts.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: the write-back bypass described above is active.
- Undefined: operands are always the regfile data (or 0 for x0); the regfile must then write in the first half-cycle. Hazard and bubble logic is unchanged.

Test Plan:
- Reset, then iValid=1, iInstr=32'h00500093 (addi x1,x0,5), PC=0x100 -> next cycle: oValid=1, oRd=1, oImm=5, oRs1Data=0, oPC=0x100.
- iInstr=32'hFE208EE3 (beq x1,x2,-4) -> oImm=32'hFFFFFFFC, oOpcode=7'h63.
- iExMemRead=1, iExRd=2, iInstr=add x3,x1,x2 -> oReady=0; next cycle oValid=0 and oBubbleCnt=1. Clear iExMemRead -> the add issues one cycle later.
- iWbEn=1, iWbRd=1, iWbData=32'hDEADBEEF, iRs1Data=0, instr reads x1:
  - with ID_WB_BYPASS_EN: oRs1Data=DEADBEEF;
  - without ID_WB_BYPASS_EN: oRs1Data=0.
  - iWbRd=0 -> oRs1Data=0.
- iStall=1 for 3 cycles with a valid slot latched -> all outputs constant, oReady=0. iFlush=1 together with iStall -> next cycle oValid=0, oReady=1.
- iInstr=32'hFFFFFFFF -> oIllegal=1, oValid=1. iRst asserted during a load-use stall -> next cycle all outputs at reset values and oBubbleCnt=0.
